// File: rtl/unsaved_counter_if.sv
// Command/result bundle for unsaved_counter.
// The master drives the load/divide/decrement commands and the operand.
// The slave (the counter) returns the count and its zero flag.
interface unsaved_counter_if #(
  parameter int WIDTH = 8
);
  logic             latch_readdata;
  logic             div_readdata;
  logic             dec_readdata;
  logic [WIDTH-1:0] in_readdata;
  logic [WIDTH-1:0] count_writedata;
  logic             zero_writedata;

  modport master (
    output latch_readdata,
    output div_readdata,
    output dec_readdata,
    output in_readdata,
    input  count_writedata,
    input  zero_writedata
  );

  modport slave (
    input  latch_readdata,
    input  div_readdata,
    input  dec_readdata,
    input  in_readdata,
    output count_writedata,
    output zero_writedata
  );
endinterface

// File: rtl/unsaved_counter.sv
// Loadable down-counter with single-cycle unsigned divide and saturating
// decrement. Command priority per edge: reset, latch, div, dec, hold.
// The count register drives the count output directly; the zero flag is
// decoded from that register so both are valid in the same cycle.
module unsaved_counter #(
  parameter int WIDTH = 8
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,  // active-high despite the name
  unsaved_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Unsigned divide that leaves the dividend untouched on a zero divisor,
  // so divide-by-zero behaves as a hold with no error reporting.
  function automatic logic [WIDTH-1:0] safe_div(
    input logic [WIDTH-1:0] num,
    input logic [WIDTH-1:0] den
  );
    logic [WIDTH-1:0] res;
    if (den == ZERO_C) begin
      res = num;
    end else begin
      res = num / den;
    end
    return res;
  endfunction

  // Decrement that sticks at zero instead of wrapping to all-ones.
  function automatic logic [WIDTH-1:0] sat_dec(
    input logic [WIDTH-1:0] val
  );
    logic [WIDTH-1:0] res;
    if (val == ZERO_C) begin
      res = ZERO_C;
    end else begin
      res = val - ONE_C;
    end
    return res;
  endfunction

  // Next-count selection: latch beats div beats dec; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (bus.latch_readdata) begin
      count_d = bus.in_readdata;
    end else if (bus.div_readdata) begin
      count_d = safe_div(count_q, bus.in_readdata);
    end else if (bus.dec_readdata) begin
      count_d = sat_dec(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset overriding any command.
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n) begin
      count_q <= ZERO_C;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count_writedata = count_q;
  assign bus.zero_writedata  = (count_q == ZERO_C);

endmodule

// File: tb/tb_unsaved_counter.sv
// Directed, table-driven bench for unsaved_counter with a few hand-written
// multi-cycle sequences (hold with random operand, mid-sequence reset).
module tb_unsaved_counter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  unsaved_counter_if #(.WIDTH(8)) bus_if ();

  unsaved_counter #(.WIDTH(8)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst),
    .bus           (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       latch;
    logic       div;
    logic       dec;
    logic [7:0] din;
    logic [7:0] exp_count;
    logic       exp_zero;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  // Drive one command at the falling edge, then check just after the rise.
  task automatic step(input string name, input logic r, input logic l,
                      input logic dv, input logic dc, input logic [7:0] din,
                      input logic [7:0] exp_count, input logic exp_zero);
    @(negedge clk);
    rst                   = r;
    bus_if.latch_readdata = l;
    bus_if.div_readdata   = dv;
    bus_if.dec_readdata   = dc;
    bus_if.in_readdata    = din;
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (bus_if.count_writedata !== exp_count || bus_if.zero_writedata !== exp_zero) begin
      failures = failures + 1;
      $display("FAIL %s: got count=%0d zero=%0b, expected count=%0d zero=%0b",
               name, bus_if.count_writedata, bus_if.zero_writedata, exp_count, exp_zero);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                   = 1'b1;
    bus_if.latch_readdata = 1'b0;
    bus_if.div_readdata   = 1'b0;
    bus_if.dec_readdata   = 1'b0;
    bus_if.in_readdata    = 8'h00;

    //          rst   latch div   dec   in      count   zero
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'd0,   1'b1}; // reset beats latch
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'd0,   1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd16, 8'd16,  1'b0}; // latch 16
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  8'd16,  1'b0}; // div by 0 holds
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  8'd8,   1'b0}; // 16/2
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd11, 8'd0,   1'b1}; // 8/11
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3,  8'd3,   1'b0}; // latch 3
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd2,   1'b0}; // dec
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd1,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd0,   1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd0,   1'b1}; // no wrap
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd40, 8'd40,  1'b0}; // latch wins
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd4,  8'd10,  1'b0}; // div beats dec
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd3,  8'd3,   1'b0}; // 10/3 floors
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd2,   1'b0}; // dec ignores in
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 1'b0}; // full-scale load
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd7,  8'd254, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].latch, vecs[i].div,
           vecs[i].dec, vecs[i].din, vecs[i].exp_count, vecs[i].exp_zero);
    end

    // Hold with a wandering operand, then divide by 1 and by full scale.
    step("hold_latch200", 1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'd200, 1'b0);
    for (int h = 0; h < 3; h++) begin
      step($sformatf("hold%0d", h), 1'b0, 1'b0, 1'b0, 1'b0,
           8'($urandom_range(0, 255)), 8'd200, 1'b0);
    end
    step("div_by_1", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd200, 1'b0);
    step("div_by_255", 1'b0, 1'b0, 1'b1, 1'b0, 8'd255, 8'd0, 1'b1);

    // Reset in the middle of a decrement sequence.
    step("mid_latch100", 1'b0, 1'b1, 1'b0, 1'b0, 8'd100, 8'd100, 1'b0);
    step("mid_dec", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd99, 1'b0);
    step("mid_reset_dec", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1);
    step("mid_latch7", 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
